frame_reader: RTL

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/frame_reader.sv
// Frame reader: pops pixels from a first-word-fall-through FIFO and streams them downstream as
// valid/ready frames with sof/eol/eof markers. Define FRAME_READER_CHECKSUM_EN to add a per-frame checksum.
module frame_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  frame_done,
  output logic [15:0]           frame_count
`ifdef FRAME_READER_CHECKSUM_EN
  ,
  output logic [31:0]           frame_checksum,
  output logic                  checksum_valid
`endif
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FRAME_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             pop;
  logic             accept;
  logic             col_last;
  logic             row_last;

  assign accept   = out_valid & out_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        // A held eof pixel blocks further pops until the consumer takes it.
        pop = !in_empty && (!out_valid || out_ready) && !(out_valid && out_eof);
        if (accept && out_eof) state_next = FRAME_DONE;
      end
      FRAME_DONE: begin
        frame_done = 1'b1;
        state_next = start ? STREAM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so no FIFO word is lost while the reset edge discards the pipeline.
  assign in_rd_en = pop & reset;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        out_data  <= in_dout;
        out_valid <= 1'b1;
        out_sof   <= (col == '0) && (row == '0);
        out_eol   <= col_last;
        out_eof   <= col_last && row_last;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end else if (accept) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef FRAME_READER_CHECKSUM_EN
  logic [31:0] cks_acc;
  logic [31:0] cks_sum;

  // The sof pixel restarts the sum rather than adding to the previous frame.
  assign cks_sum        = (out_sof ? 32'd0 : cks_acc) + 32'(out_data);
  assign checksum_valid = frame_done;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cks_acc        <= '0;
      frame_checksum <= '0;
    end else begin
      if (accept) cks_acc <= cks_sum;
      if (accept && out_eof) frame_checksum <= cks_sum;
    end
  end
`endif

endmodule
